// File: rtl/fetch_unit_if.sv
// Fetch-side bus: decode control in, instruction memory port, registered
// instruction out to decode.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall;
    logic                   is_branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic [PC_WIDTH-1:0]    pc_out;

    modport master (
        input  stall, is_branch_taken, branch_target, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc_out
    );

    modport slave (
        output stall, is_branch_taken, branch_target, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited prefetch FIFO,
// registered instruction output with stall and branch flush.
module fetch_unit #(
    parameter int                  DEPTH       = 4,
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    req_pc;
    logic                   inflight;
    logic [AW:0]            count;
    logic [AW:0]            used;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [PC_WIDTH-1:0]    addr_q [DEPTH];
    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic                   flush;
    logic                   req;
    logic                   push;
    logic                   pop;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic                   valid_r;
    logic [PC_WIDTH-1:0]    pc_r;

    // An in-flight read holds a credit, so its push always finds space.
    assign flush = bus.is_branch_taken;
    assign used  = count + {{AW{1'b0}}, inflight};
    assign req   = reset && !flush && (used < DEPTH_C);
    assign push  = inflight && !flush;
    assign pop   = !flush && !bus.stall && (count != '0);

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = valid_r;
    assign bus.pc_out      = pc_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            pc       <= bus.branch_target;
            inflight <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                pc     <= pc + PC_WIDTH'(1);
                req_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= req_pc;
            data_q[wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_r <= '0;
            valid_r <= 1'b0;
            pc_r    <= '0;
        end else if (flush) begin
            instr_r <= '0;
            valid_r <= 1'b0;
            pc_r    <= '0;
        end else if (bus.stall) begin
            instr_r <= instr_r;
            valid_r <= valid_r;
            pc_r    <= pc_r;
        end else if (pop) begin
            instr_r <= data_q[rd_ptr];
            valid_r <= 1'b1;
            pc_r    <= addr_q[rd_ptr];
        end else begin
            instr_r <= '0;
            valid_r <= 1'b0;
            pc_r    <= '0;
        end
    end
endmodule
